// File: rtl/tt_pkg.sv
// rtl/tt_pkg.sv - shared types and constants for the result datapath stages
package tt_pkg;
   localparam int DATA_W     = 8;
   localparam int FRAME_BITS = 10;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;
endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - circular-buffer FIFO with combinational head read
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         din,
   input  logic                     pop,
   output logic [WIDTH-1:0]         dout,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);
   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == (PTR_W+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   // Pointers are exactly PTR_W bits so they wrap on their own at DEPTH.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end
endmodule

// File: rtl/result_uart_tx.sv
// rtl/result_uart_tx.sv - buffers result bytes and shifts them out as 8N1 serial frames
module result_uart_tx
   import tt_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [DATA_W-1:0]              in_data,
   input  logic                           in_valid,
   output logic                           in_ready,
   output logic                           tx,
   output logic                           busy,
   output logic [$clog2(FIFO_DEPTH):0]    fifo_count,
   output logic [7:0]                     frame_count
);
   localparam int BAUD_W = $clog2(CLKS_PER_BIT);

   uart_state_t       state;
   uart_state_t       state_next;
   logic [BAUD_W-1:0] baud_cnt;
   logic [BAUD_W-1:0] baud_next;
   logic [2:0]        bit_idx;
   logic [2:0]        bit_next;
   logic [DATA_W-1:0] shift;
   logic [DATA_W-1:0] shift_next;
   logic [7:0]        frame_next;
   logic              tx_next;
   logic              push;
   logic              pop;
   logic [DATA_W-1:0] fifo_dout;
   logic              fifo_full;
   logic              fifo_empty;
   logic              baud_done;
   logic              last_bit;

   assign in_ready  = !fifo_full && !reset;
   assign push      = in_valid && in_ready;
   assign baud_done = (baud_cnt == BAUD_W'(CLKS_PER_BIT - 1));
   assign last_bit  = (bit_idx == 3'(FRAME_BITS - 3));
   assign busy      = (state != IDLE);

   sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .din   (in_data),
      .pop   (pop),
      .dout  (fifo_dout),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (!fifo_empty) state_next = START;
         START:   if (baud_done) state_next = DATA;
         DATA:    if (baud_done && last_bit) state_next = STOP;
         STOP:    if (baud_done) state_next = fifo_empty ? IDLE : START;
         default: state_next = IDLE;
      endcase
   end

   // Every state change out of a timed state lands on baud_done, so the
   // baud counter only needs clearing there and while idle.
   always_comb begin
      pop        = 1'b0;
      baud_next  = baud_cnt + 1'b1;
      bit_next   = bit_idx;
      shift_next = shift;
      frame_next = frame_count;
      if (state == IDLE || baud_done) baud_next = '0;
      case (state)
         IDLE: begin
            if (!fifo_empty) begin
               pop        = 1'b1;
               shift_next = fifo_dout;
            end
         end
         START: if (baud_done) bit_next = '0;
         DATA: begin
            if (baud_done) begin
               shift_next = shift >> 1;
               bit_next   = bit_idx + 3'd1;
            end
         end
         STOP: begin
            if (baud_done) begin
               frame_next = frame_count + 8'd1;
               if (!fifo_empty) begin
                  pop        = 1'b1;
                  shift_next = fifo_dout;
               end
            end
         end
         default: ;
      endcase
      case (state_next)
         START:   tx_next = 1'b0;
         DATA:    tx_next = shift_next[0];
         default: tx_next = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         baud_cnt    <= '0;
         bit_idx     <= '0;
         shift       <= '0;
         tx          <= 1'b1;
         frame_count <= '0;
      end else begin
         baud_cnt    <= baud_next;
         bit_idx     <= bit_next;
         shift       <= shift_next;
         tx          <= tx_next;
         frame_count <= frame_next;
      end
   end
endmodule

// File: tb/tb_result_uart_tx.sv
// tb/tb_result_uart_tx.sv - directed bench for result_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4
module tb_result_uart_tx;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] in_data = 8'h00;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic       tx;
   logic       busy;
   logic [2:0] fifo_count;
   logic [7:0] frame_count;

   int n_checks = 0;
   int n_fail   = 0;

   int         cyc = 0;
   int         rx_ph = 0;
   int         rx_start = 0;
   logic [9:0] rx_sh = '0;
   logic [9:0] rx_q[$];
   int         rx_t[$];
   logic [7:0] exp_q[$];

   typedef struct {
      logic [7:0] data;
      logic [9:0] frame;
   } vec_t;

   result_uart_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut (
      .clk         (clk),
      .reset       (reset),
      .in_data     (in_data),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .tx          (tx),
      .busy        (busy),
      .fifo_count  (fifo_count),
      .frame_count (frame_count)
   );

   always #5 clk = ~clk;

   // Line receiver: samples tx mid-bit; frame bit i holds the i-th sample.
   initial begin
      forever begin
         @(posedge clk); #1;
         cyc++;
         if (reset) begin
            rx_ph = 0;
         end else if (rx_ph == 0) begin
            if (tx == 1'b0) begin
               rx_ph    = 1;
               rx_start = cyc;
            end
         end else begin
            if (rx_ph >= 2 && (rx_ph - 2) % 4 == 0) rx_sh = {tx, rx_sh[9:1]};
            if (rx_ph == 38) begin
               rx_q.push_back(rx_sh);
               rx_t.push_back(rx_start);
            end
            rx_ph = (rx_ph == 39) ? 0 : rx_ph + 1;
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset    = 1'b1;
      in_valid = 1'b0;
      tick();
      tick();
      check("rst_tx", tx, 1);
      check("rst_busy", busy, 0);
      check("rst_in_ready", in_ready, 0);
      check("rst_fifo_count", fifo_count, 0);
      check("rst_frame_count", frame_count, 0);
      @(negedge clk);
      reset = 1'b0;
      tick();
      check("rst_in_ready_after", in_ready, 1);
      rx_q.delete();
      rx_t.delete();
      exp_q.delete();
   endtask

   task automatic push_byte(input logic [7:0] b, output int waited);
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = b;
      waited   = 0;
      while (!in_ready && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      if (!in_ready) begin
         n_checks++;
         n_fail++;
         $display("FAIL push_timeout: byte %02h got no in_ready within %0d cycles", b, waited);
      end
      tick();
   endtask

   task automatic idle_in();
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic check_frames(input string name, input bit contiguous, input int budget);
      int         k;
      int         prev;
      int         t;
      logic [7:0] e;
      logic [9:0] f;
      k = 0;
      while ((rx_q.size() < exp_q.size() || busy) && k < budget) begin
         tick();
         k++;
      end
      check({name, "_nframes"}, rx_q.size(), exp_q.size());
      k    = 0;
      prev = 0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (rx_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: got no frame expected byte %02h", name, e);
         end else begin
            f = rx_q.pop_front();
            t = rx_t.pop_front();
            check(name, f, {1'b1, e, 1'b0});
            if (contiguous && k > 0) check({name, "_gap"}, t - prev, 40);
            prev = t;
         end
         k++;
      end
      check({name, "_extra"}, rx_q.size(), 0);
   endtask

   initial begin
      vec_t vecs[5];
      int   w;
      int   n;
      int   tx_low;

      vecs[0] = '{8'hA5, 10'b1101001010};
      vecs[1] = '{8'h00, 10'b1000000000};
      vecs[2] = '{8'hFF, 10'b1111111110};
      vecs[3] = '{8'h3C, 10'b1001111000};
      vecs[4] = '{8'h81, 10'b1100000010};

      do_reset();

      // Single frames from idle, one table entry at a time.
      for (int i = 0; i < 5; i++) begin
         push_byte(vecs[i].data, w);
         check("t1_count_e0", fifo_count, 1);
         check("t1_tx_e0", tx, 1);
         idle_in();
         tick();
         check("t1_tx_start", tx, 0);
         check("t1_busy_start", busy, 1);
         check("t1_count_e1", fifo_count, 0);
         n = 0;
         while (busy && n < 100) begin
            n++;
            tick();
         end
         check("t1_busy_cycles", n, 40);
         if (rx_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL t1_frame: got no frame expected %03h", vecs[i].frame);
         end else begin
            check("t1_frame", rx_q.pop_front(), vecs[i].frame);
            void'(rx_t.pop_front());
         end
         check("t1_frame_count", frame_count, i + 1);
      end

      // Back-to-back with in_valid held through the full condition.
      do_reset();
      for (int i = 0; i < 5; i++) begin
         push_byte(8'h10 + 8'(i), w);
         check("t2_wait", w, 0);
      end
      check("t2_full_count", fifo_count, 4);
      check("t2_full_ready", in_ready, 0);
      push_byte(8'h15, w);
      check("t2_wait_15", w, 37);
      idle_in();
      for (int i = 0; i < 6; i++) exp_q.push_back(8'h10 + 8'(i));
      check_frames("t2_frame", 1, 400);
      check("t2_frame_count", frame_count, 6);

      // Backpressure: 0x77 held while full goes out exactly once.
      do_reset();
      for (int i = 0; i < 5; i++) push_byte(8'h20 + 8'(i), w);
      push_byte(8'h77, w);
      check("t3_wait_77", w, 37);
      idle_in();
      for (int i = 0; i < 5; i++) exp_q.push_back(8'h20 + 8'(i));
      exp_q.push_back(8'h77);
      check_frames("t3_frame", 1, 400);
      repeat (60) tick();
      check("t3_no_dup", rx_q.size(), 0);
      check("t3_idle", busy, 0);
      check("t3_frame_count", frame_count, 6);

      // Reset during DATA bit 3 of 0x3C with two bytes queued.
      do_reset();
      push_byte(8'h3C, w);
      push_byte(8'h41, w);
      push_byte(8'h42, w);
      check("t4_queued", fifo_count, 2);
      idle_in();
      repeat (16) @(posedge clk);
      #1;
      check("t4_bit3", tx, 1);
      @(negedge clk);
      reset = 1'b1;
      tick();
      check("t4_tx", tx, 1);
      check("t4_busy", busy, 0);
      check("t4_fifo_count", fifo_count, 0);
      check("t4_frame_count", frame_count, 0);
      @(negedge clk);
      reset = 1'b0;
      tx_low = 0;
      repeat (80) begin
         tick();
         if (tx == 1'b0) tx_low++;
      end
      check("t4_tx_quiet", tx_low, 0);
      check("t4_no_frames", rx_q.size(), 0);
      check("t4_frame_count_after", frame_count, 0);

      // 256 frames: frame counter wraps, FIFO pointers wrap many times.
      do_reset();
      for (int i = 0; i < 256; i++) begin
         push_byte(8'h00, w);
         exp_q.push_back(8'h00);
      end
      idle_in();
      check_frames("t5_frame", 1, 2000);
      check("t5_frame_count_wrap", frame_count, 0);

      // Push lands on the STOP edge that pops the head.
      do_reset();
      push_byte(8'hD1, w);
      push_byte(8'hD2, w);
      push_byte(8'hD3, w);
      idle_in();
      check("t6_queued", fifo_count, 2);
      repeat (38) @(posedge clk);
      #1;
      check("t6_count_before", fifo_count, 2);
      push_byte(8'hC3, w);
      check("t6_wait", w, 0);
      check("t6_count_same", fifo_count, 2);
      check("t6_busy", busy, 1);
      idle_in();
      exp_q.push_back(8'hD1);
      exp_q.push_back(8'hD2);
      exp_q.push_back(8'hD3);
      exp_q.push_back(8'hC3);
      check_frames("t6_frame", 1, 400);
      check("t6_frame_count", frame_count, 4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
